data_unloader: RTL and testbench

Reverse of the bridge-to-memory loader. It services APF bridge reads by fetching two 16-bit words from a local memory and assembling them into the 32-bit bridge_rd_data word. It prefetches the next sequential 32-bit word so that streamed host reads hit without waiting on memory. The block sits entirely in the clk_74a bridge domain, between the APF bridge and a 16-bit read port on core memory.

---
 rtl/data_unloader.sv | 186 ++++++++++++++++++
 tb/tb_data_unloader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_unloader.sv
// APF bridge read path: fetches two 16-bit memory words per 32-bit host read,
// applies byte order at the output, and prefetches the next sequential word.
module data_unloader #(
  parameter int         ADDRESS_SIZE         = 15,
  parameter logic [3:0] ADDRESS_MASK_UPPER_4 = 4'h1
) (
  input  logic                    clk_74a,
  input  logic                    reset_n,
  input  logic                    bridge_rd,
  input  logic                    bridge_endian_little,
  input  logic [31:0]             bridge_addr,
  output logic [31:0]             bridge_rd_data,
  output logic                    read_en,
  output logic [ADDRESS_SIZE-1:0] read_addr,
  input  logic [15:0]             read_data,
  input  logic                    read_data_valid,
  output logic                    busy
);

  typedef logic [ADDRESS_SIZE-1:0] addr_t;

  typedef enum logic [2:0] {
    IDLE,
    REQ_LO,
    WAIT_LO,
    REQ_HI,
    WAIT_HI,
    DRAIN
  } state_e;

  localparam addr_t HALF_STEP = addr_t'(2);
  localparam addr_t WORD_STEP = addr_t'(4);

  state_e      state_q,      state_d;
  addr_t       fetch_addr_q, fetch_addr_d;
  addr_t       read_addr_q,  read_addr_d;
  addr_t       pend_addr_q,  pend_addr_d;
  addr_t       buf_tag_q,    buf_tag_d;
  logic        pend_q,       pend_d;
  logic        demand_q,     demand_d;
  logic        buf_valid_q,  buf_valid_d;
  logic [15:0] lo_q,         lo_d;
  logic [15:0] buf_lo_q,     buf_lo_d;
  logic [15:0] buf_hi_q,     buf_hi_d;
  logic [31:0] rd_data_q,    rd_data_d;

  logic  sel;
  addr_t req_addr;
  logic  start;
  addr_t start_addr;

  // Address bits above the memory window and the byte lane bits play no part.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bridge_addr[27:ADDRESS_SIZE], bridge_addr[1:0]};

  assign sel      = bridge_rd && (bridge_addr[31:28] == ADDRESS_MASK_UPPER_4);
  assign req_addr = {bridge_addr[ADDRESS_SIZE-1:2], 2'b00};

  // Buffer holds raw memory words; byte order is chosen only here.
  function automatic logic [31:0] assemble(input logic [15:0] lo,
                                           input logic [15:0] hi,
                                           input logic        little);
    if (little) return {hi, lo};
    return {lo[7:0], lo[15:8], hi[7:0], hi[15:8]};
  endfunction

  always_comb begin
    // NOTE: every _d takes its hold value first, so no path through this block can infer a latch.
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    read_addr_d  = read_addr_q;
    pend_addr_d  = pend_addr_q;
    buf_tag_d    = buf_tag_q;
    pend_d       = pend_q;
    demand_d     = demand_q;
    buf_valid_d  = buf_valid_q;
    lo_d         = lo_q;
    buf_lo_d     = buf_lo_q;
    buf_hi_d     = buf_hi_q;
    rd_data_d    = rd_data_q;
    start        = 1'b0;
    start_addr   = req_addr;

    if (sel && (state_q != IDLE) && (state_q != DRAIN)) begin
      pend_d      = 1'b1;
      pend_addr_d = req_addr;
    end

    case (state_q)
      IDLE:   start = sel;
      REQ_LO: state_d = WAIT_LO;
      WAIT_LO: begin
        if (read_data_valid) begin
          if (pend_q) begin
            state_d = DRAIN;
          end else begin
            lo_d        = read_data;
            read_addr_d = fetch_addr_q + HALF_STEP;
            state_d     = REQ_HI;
          end
        end
      end
      REQ_HI: state_d = WAIT_HI;
      WAIT_HI: begin
        if (read_data_valid) begin
          if (pend_q) begin
            state_d = DRAIN;
          end else begin
            buf_lo_d    = lo_q;
            buf_hi_d    = read_data;
            buf_tag_d   = fetch_addr_q;
            buf_valid_d = 1'b1;
            if (demand_q) begin
              // Demand fill answers the host, then streams straight into the prefetch.
              rd_data_d    = assemble(lo_q, read_data, bridge_endian_little);
              demand_d     = 1'b0;
              fetch_addr_d = fetch_addr_q + WORD_STEP;
              read_addr_d  = fetch_addr_d;
              state_d      = REQ_LO;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      DRAIN: begin
        start      = 1'b1;
        pend_d     = 1'b0;
        start_addr = sel ? req_addr : pend_addr_q;
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      buf_valid_d = 1'b0;
      state_d     = REQ_LO;
      if (buf_valid_q && (buf_tag_q == start_addr)) begin
        rd_data_d    = assemble(buf_lo_q, buf_hi_q, bridge_endian_little);
        demand_d     = 1'b0;
        fetch_addr_d = start_addr + WORD_STEP;
      end else begin
        demand_d     = 1'b1;
        fetch_addr_d = start_addr;
      end
      read_addr_d = fetch_addr_d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      fetch_addr_q <= '0;
      read_addr_q  <= '0;
      pend_addr_q  <= '0;
      buf_tag_q    <= '0;
      pend_q       <= 1'b0;
      demand_q     <= 1'b0;
      buf_valid_q  <= 1'b0;
      // NOTE: the buffer words are plain flops, not a RAM, so they reset with everything else.
      lo_q         <= '0;
      buf_lo_q     <= '0;
      buf_hi_q     <= '0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      read_addr_q  <= read_addr_d;
      pend_addr_q  <= pend_addr_d;
      buf_tag_q    <= buf_tag_d;
      pend_q       <= pend_d;
      demand_q     <= demand_d;
      buf_valid_q  <= buf_valid_d;
      lo_q         <= lo_d;
      buf_lo_q     <= buf_lo_d;
      buf_hi_q     <= buf_hi_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign bridge_rd_data = rd_data_q;
  assign read_addr      = read_addr_q;
  assign read_en        = (state_q == REQ_LO) || (state_q == REQ_HI);
  assign busy           = (state_q != IDLE) || pend_q;

endmodule

// File: tb/tb_data_unloader.sv
// Bench for data_unloader: byte-stream memory model, fetch-address scoreboard,
// per-cycle read-data tracker and directed host reads with literal expectations.
module tb_data_unloader;

  localparam int AS      = 15;
  localparam int MEM_LAT = 2;

  logic          clk_74a              = 1'b0;
  logic          reset_n              = 1'b0;
  logic          bridge_rd            = 1'b0;
  logic          bridge_endian_little = 1'b0;
  logic [31:0]   bridge_addr          = '0;
  logic [31:0]   bridge_rd_data;
  logic          read_en;
  logic [AS-1:0] read_addr;
  logic [15:0]   read_data            = '0;
  logic          read_data_valid      = 1'b0;
  logic          busy;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0]   mem [0:(1<<(AS-1))-1];
  logic [AS-1:0] exp_fetch [$];
  logic [31:0]   exp_rd         = '0;
  logic [31:0]   exp_next       = '0;
  logic          exp_next_valid = 1'b0;
  int            mem_cnt        = 0;
  logic [AS-1:0] mem_addr       = '0;

  always #5 clk_74a = ~clk_74a;

  data_unloader #(
    .ADDRESS_SIZE        (AS),
    .ADDRESS_MASK_UPPER_4(4'h1)
  ) dut (
    .clk_74a             (clk_74a),
    .reset_n             (reset_n),
    .bridge_rd           (bridge_rd),
    .bridge_endian_little(bridge_endian_little),
    .bridge_addr         (bridge_addr),
    .bridge_rd_data      (bridge_rd_data),
    .read_en             (read_en),
    .read_addr           (read_addr),
    .read_data           (read_data),
    .read_data_valid     (read_data_valid),
    .busy                (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory viewed as a byte stream: each 16-bit word holds its even-address
  // byte in bits [7:0]. Big endian lists bytes A..A+3 MSB first.
  function automatic logic [31:0] model_word(input logic [AS-1:0] a, input logic little);
    logic [AS-1:0] a_hi;
    logic [7:0]    b [4];
    a_hi = a + AS'(2);
    b[0] = mem[a[AS-1:1]][7:0];
    b[1] = mem[a[AS-1:1]][15:8];
    b[2] = mem[a_hi[AS-1:1]][7:0];
    b[3] = mem[a_hi[AS-1:1]][15:8];
    if (little) return {b[3], b[2], b[1], b[0]};
    return {b[0], b[1], b[2], b[3]};
  endfunction

  // Miss on A: host word from A, then fetches A, A+2 and prefetch A+4, A+6.
  task automatic expect_demand(input logic [AS-1:0] a, input logic little);
    exp_next       = model_word(a, little);
    exp_next_valid = 1'b1;
    for (int i = 0; i < 4; i++) exp_fetch.push_back(a + AS'(2 * i));
  endtask

  // Hit on A: host word from the buffer, then prefetch fetches from A+4.
  task automatic expect_hit(input logic [AS-1:0] a, input logic little, input int n_fetch);
    exp_next       = model_word(a, little);
    exp_next_valid = 1'b1;
    for (int i = 0; i < n_fetch; i++) exp_fetch.push_back(a + AS'(4 + 2 * i));
  endtask

  task automatic issue(input logic [31:0] addr);
    @(negedge clk_74a); #1;
    bridge_addr = addr;
    bridge_rd   = 1'b1;
    @(negedge clk_74a); #1;
    bridge_rd   = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (busy && n < max_cycles) begin
      @(negedge clk_74a); #1;
      n++;
    end
    check("busy_falls", 32'(busy), 0);
    check("fetch_queue_drained", 32'(exp_fetch.size()), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_data"},   bridge_rd_data, 0);
    check({tag, "_read_en"},   32'(read_en), 0);
    check({tag, "_read_addr"}, 32'(read_addr), 0);
    check({tag, "_busy"},      32'(busy), 0);
  endtask

  // Compare process and memory responder, both on the falling edge.
  always @(negedge clk_74a) begin
    if (!reset_n) begin
      exp_fetch.delete();
      exp_rd          = '0;
      exp_next_valid  = 1'b0;
      mem_cnt         = 0;
      read_data_valid = 1'b0;
    end else begin
      if (exp_next_valid && bridge_rd_data === exp_next) begin
        exp_rd         = exp_next;
        exp_next_valid = 1'b0;
      end
      check("rd_data_track", bridge_rd_data, exp_rd);
      if (read_en) begin
        check("read_en_while_outstanding", 32'(mem_cnt), 0);
        if (exp_fetch.size() == 0) check("read_en_unexpected", 32'(read_en), 0);
        else check("read_addr", 32'(read_addr), 32'(exp_fetch.pop_front()));
      end
      read_data_valid = 1'b0;
      if (mem_cnt > 0) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          read_data_valid = 1'b1;
          read_data       = mem[mem_addr[AS-1:1]];
        end
      end
      if (read_en) begin
        mem_addr = read_addr;
        mem_cnt  = MEM_LAT;
      end
    end
  end

  initial begin
    for (int i = 0; i < (1 << (AS - 1)); i++) mem[i] = 16'(i) ^ 16'h5A3C;
    mem[15'h0C >> 1]   = 16'hBBAA;
    mem[15'h0E >> 1]   = 16'hDDCC;
    mem[15'h10 >> 1]   = 16'hFFEE;
    mem[15'h12 >> 1]   = 16'hDDCC;
    mem[15'h40 >> 1]   = 16'h1122;
    mem[15'h42 >> 1]   = 16'h3344;
    mem[15'h44 >> 1]   = 16'h5566;
    mem[15'h46 >> 1]   = 16'h7788;
    mem[15'h7FFC >> 1] = 16'hA1B2;
    mem[15'h7FFE >> 1] = 16'hC3D4;
    mem[0]             = 16'h0F1E;
    mem[1]             = 16'h2D3C;

    // Reset held, then idle.
    repeat (3) @(negedge clk_74a);
    #1 check_reset_outputs("in_reset");
    reset_n = 1'b1;
    repeat (10) @(negedge clk_74a);
    #1 check_reset_outputs("idle");

    // Miss, big endian.
    expect_demand(15'h0C, 1'b0);
    issue(32'h1000000C);
    check("miss_busy", 32'(busy), 1);
    wait_idle(60);
    check("miss_be_data", bridge_rd_data, 32'hAABBCCDD);

    // Sequential hit; then abort its prefetch while it waits for the low word.
    expect_hit(15'h10, 1'b0, 1);
    issue(32'h10000010);
    check("hit_data", bridge_rd_data, 32'hEEFFCCDD);
    check("hit_busy", 32'(busy), 1);
    expect_demand(15'h40, 1'b0);
    issue(32'h10000040);
    wait_idle(80);
    check("abort_data", bridge_rd_data, 32'h22114433);

    // Hit served from the prefetch left behind by the aborted stream.
    expect_hit(15'h44, 1'b0, 2);
    issue(32'h10000044);
    check("hit_after_abort", bridge_rd_data, 32'h66558877);
    wait_idle(60);

    // Wrap at the top of memory; address bits above the window and bits [1:0] ignored.
    expect_demand(15'h7FFC, 1'b0);
    issue(32'h1000FFFE);
    wait_idle(60);
    check("wrap_miss_data", bridge_rd_data, 32'hB2A1D4C3);
    expect_hit(15'h0000, 1'b0, 2);
    issue(32'h10000000);
    check("wrap_hit_data", bridge_rd_data, 32'h1E0F3C2D);
    wait_idle(60);

    // Little endian miss; the prefetch filled under little endian then serves a big-endian hit.
    bridge_endian_little = 1'b1;
    expect_demand(15'h0C, 1'b1);
    issue(32'h1000000C);
    wait_idle(60);
    check("miss_le_data", bridge_rd_data, 32'hDDCCBBAA);
    bridge_endian_little = 1'b0;
    expect_hit(15'h10, 1'b0, 2);
    issue(32'h10000010);
    check("endian_switch_hit", bridge_rd_data, 32'hEEFFCCDD);
    wait_idle(60);

    // Deselected read.
    issue(32'h2000000C);
    for (int i = 0; i < 5; i++) begin
      check("deselect_busy", 32'(busy), 0);
      @(negedge clk_74a); #1;
    end
    check("deselect_data", bridge_rd_data, 32'hEEFFCCDD);

    // Reset during the prefetch WAIT_HI, with the demand word held in the buffer.
    expect_demand(15'h0C, 1'b0);
    issue(32'h1000000C);
    repeat (10) @(negedge clk_74a);
    #1;
    check("pre_reset_addr", 32'(read_addr), 32'h12);
    check("pre_reset_data", bridge_rd_data, 32'hAABBCCDD);
    check("pre_reset_busy", 32'(busy), 1);
    reset_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    repeat (3) @(negedge clk_74a);
    #1 reset_n = 1'b1;
    repeat (3) @(negedge clk_74a);
    #1;
    expect_demand(15'h0C, 1'b0);
    issue(32'h1000000C);
    check("post_reset_miss_busy", 32'(busy), 1);
    wait_idle(60);
    check("post_reset_data", bridge_rd_data, 32'hAABBCCDD);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
